// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//   Instruction fetch stage feeding decode. Holds a word-granular PC, reads
//   one word per cycle from a combinational-read main memory and buffers the
//   words, tagged with their PC, in a DEPTH-entry FIFO.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   fetch_enable      allow fetching
//   mem_read_address  memory read address (the pc register)
//   mem_read_data     memory word at mem_read_address, same cycle
//   redirect_valid    flush queue and restart at redirect_pc
//   redirect_pc       new word-address PC
//   instr_valid/ready valid/ready handshake to decode
//   instr_data/pc     head word and its PC
//   occupancy         number of queued entries
//   fetch_fault       sticky: fetch attempted at pc >= MEM_DEPTH
module fetch_prefetch_queue #(
    parameter int DEPTH     = 4,
    parameter int RESET_PC  = 0,
    parameter int MEM_DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_enable,
    output logic [31:0]              mem_read_address,
    input  logic [31:0]              mem_read_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     fetch_fault
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);
    localparam logic [31:0] PC_RST    = 32'(RESET_PC);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [31:0]     pc;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            fault;

    logic pop, push_ok, in_range, do_push;

    always_comb begin
        // Redirect masks the head so decode never consumes a word being flushed.
        instr_valid = (count != '0) & ~redirect_valid;
        pop         = instr_valid & instr_ready;
        // A full queue still accepts a push when the head leaves this cycle.
        push_ok     = fetch_enable & ~redirect_valid & ~fault & ((count < FULL) | pop);
        in_range    = pc < MEM_LIMIT;
        do_push     = push_ok & in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= PC_RST;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fault  <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fault  <= 1'b0;
        end else begin
            if (do_push) begin
                pc     <= pc + 32'd1;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (push_ok) begin
                // Out-of-range attempt: pc holds so the faulting address stays visible.
                fault <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately unreset; contents are only visible under instr_valid.
    always_ff @(posedge clk) begin
        if (do_push)
            fifo_q[wr_ptr] <= '{pc: pc, data: mem_read_data};
    end

    assign mem_read_address = pc;
    assign instr_data       = fifo_q[rd_ptr].data;
    assign instr_pc         = fifo_q[rd_ptr].pc;
    assign occupancy        = count;
    assign fetch_fault      = fault;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  occupancy;
    logic        fetch_fault;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Memory model: word i holds i+100; out-of-range reads return a marker.
    assign mem_read_data = (mem_read_address < 32'd2048) ? mem_read_address + 32'd100 : 32'hDEAD_BEEF;

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(0), .MEM_DEPTH(2048)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .occupancy(occupancy), .fetch_fault(fetch_fault)
    );

    typedef struct {
        logic        fe, rdy, rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  eocc;
        logic [31:0] eaddr;
        logic        efault;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic fe, logic rdy, logic rv, logic [31:0] rpc,
                                logic ev, logic [31:0] epc, logic [2:0] eocc,
                                logic [31:0] eaddr, logic efault);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eocc = eocc; v.eaddr = eaddr; v.efault = efault;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [2:0] eocc, input logic [31:0] eaddr, input logic efault);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(ev));
        chk({tag, " occupancy"}, 32'(occupancy), 32'(eocc));
        chk({tag, " mem_read_address"}, mem_read_address, eaddr);
        chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'(efault));
        if (ev) begin
            chk({tag, " instr_pc"}, instr_pc, epc);
            chk({tag, " instr_data"}, instr_data, epc + 32'd100);
        end
    endtask

    initial begin
        // fe rdy rv rpc       | valid pc  occ addr  fault
        // fill from reset, instr_ready low
        add(1,0,0,0,            0, 0,    0, 0,    0);
        add(1,0,0,0,            1, 0,    1, 1,    0);
        add(1,0,0,0,            1, 0,    2, 2,    0);
        add(1,0,0,0,            1, 0,    3, 3,    0);
        add(1,0,0,0,            1, 0,    4, 4,    0);
        add(1,0,0,0,            1, 0,    4, 4,    0);
        // full queue streaming: one pop and one push per cycle
        add(1,1,0,0,            1, 0,    4, 4,    0);
        add(1,1,0,0,            1, 1,    4, 5,    0);
        add(1,1,0,0,            1, 2,    4, 6,    0);
        add(1,1,0,0,            1, 3,    4, 7,    0);
        add(0,1,0,0,            1, 4,    4, 8,    0);
        // redirect to 0x40 at occupancy 3
        add(1,1,1,32'h40,       0, 0,    3, 8,    0);
        add(1,0,0,0,            0, 0,    0, 32'h40, 0);
        add(0,0,0,0,            1, 32'h40, 1, 32'h41, 0);
        // redirect near the end of memory, fault at 2048
        add(1,0,1,2046,         0, 0,    1, 32'h41, 0);
        add(1,0,0,0,            0, 0,    0, 2046, 0);
        add(1,0,0,0,            1, 2046, 1, 2047, 0);
        add(1,0,0,0,            1, 2046, 2, 2048, 0);
        add(1,1,0,0,            1, 2046, 2, 2048, 1);
        add(1,1,0,0,            1, 2047, 1, 2048, 1);
        add(1,1,0,0,            0, 0,    0, 2048, 1);
        add(1,0,1,0,            0, 0,    0, 2048, 1);
        add(1,0,0,0,            0, 0,    0, 0,    0);
        add(1,0,0,0,            1, 0,    1, 1,    0);
        add(0,0,0,0,            1, 0,    2, 2,    0);
        // fetch disabled: drain two entries, address frozen
        add(0,1,0,0,            1, 0,    2, 2,    0);
        add(0,1,0,0,            1, 1,    1, 2,    0);
        add(0,1,0,0,            0, 0,    0, 2,    0);
        // refill to two entries for the async reset check
        add(1,0,0,0,            0, 0,    0, 2,    0);
        add(1,0,0,0,            1, 2,    1, 3,    0);
        add(0,0,0,0,            1, 2,    2, 4,    0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_state("reset", 1'b0, 0, 3'd0, 32'd0, 1'b0);
        // redirect during reset must be ignored
        redirect_valid = 1'b1; redirect_pc = 32'h123; fetch_enable = 1'b1;
        @(posedge clk); #1;
        chk("reset redirect ignored", mem_read_address, 32'd0);
        redirect_valid = 1'b0; redirect_pc = '0; fetch_enable = 1'b0;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            fetch_enable   = tbl[i].fe;
            instr_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eocc,
                      tbl[i].eaddr, tbl[i].efault);
        end

        // asynchronous reset mid-cycle with two entries queued
        #2 rst_n = 1'b0;
        #1;
        chk("async rst instr_valid", 32'(instr_valid), 32'd0);
        chk("async rst occupancy", 32'(occupancy), 32'd0);
        chk("async rst address", mem_read_address, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; fetch_enable = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        chk_state("post-rst idle", 1'b0, 0, 3'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk_state("post-rst fetch", 1'b1, 0, 3'd1, 32'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of decode and driving the read port of main memory.
- Main memory is word-addressed, with a combinational read and a depth of 2048 words.
- The block holds a word-granular PC and reads one instruction word per cycle. It buffers fetched words, tagged with their PC, in a small FIFO.
- It hands words to decode over a valid/ready handshake, and supports redirect (branch/jump flush) and out-of-range fetch faulting.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- RESET_PC, 0: word address fetched first after reset.
- MEM_DEPTH, 2048: number of valid memory words; any PC >= MEM_DEPTH faults.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- fetch_enable  input  1  permits fetching when high.
- mem_read_address  output  32  to main memory read address; always equals the pc register.
- mem_read_data  input  32  from main memory; combinational read of mem_read_address.
- redirect_valid  input  1  flush queue and restart at redirect_pc.
- redirect_pc  input  32  new word-address PC.
- instr_valid  output  1  head entry is available to decode.
- instr_ready  input  1  decode accepts the head entry.
- instr_data  output  32  head instruction word.
- instr_pc  output  32  PC of the head word.
- occupancy  output  clog2(DEPTH)+1  current entry count.
- fetch_fault  output  1  sticky; a fetch was attempted at PC >= MEM_DEPTH.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n is low: pc = RESET_PC, count = 0, read/write pointers = 0, fetch_fault = 0.
  - Consequently instr_valid = 0 and occupancy = 0.
  - FIFO storage is not reset; instr_data/instr_pc are don't-care while instr_valid = 0.
- Reset asserted mid-operation discards all queued entries immediately.
- Memory interface: mem_read_address = pc (registered). mem_read_data is sampled in the same cycle, so fetch latency is zero cycles memory-to-queue.
- Queue-to-output latency is 1 cycle: a word fetched in cycle N is visible on instr_* in cycle N+1.
- pop = instr_valid & instr_ready.
- instr_valid = (count != 0) & ~redirect_valid. The head is registered FIFO storage, with no bypass.
- push_ok = fetch_enable & ~redirect_valid & ~fetch_fault & (count < DEPTH | pop).
  - A full queue accepts a push in the same cycle it pops.
- When push_ok and pc < MEM_DEPTH:
  - write {pc, mem_read_data} at the write pointer;
  - pc <= pc + 1;
  - count and pointers update for the push.
- When push_ok and pc >= MEM_DEPTH:
  - no push; fetch_fault <= 1; pc holds.
  - Entries already queued still drain normally.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Pop only (no push): count decrements.
- Redirect (highest priority, above push and pop):
  - count <= 0 and pointers <= 0;
  - pc <= redirect_pc; fetch_fault <= 0;
  - no push and no pop occur that cycle.
  - The first word at redirect_pc is fetched in the following cycle if push_ok.
- Redirect while rst_n is low is ignored, because reset dominates.
- fetch_enable low: pc holds and nothing is pushed; the queue still drains.
- pc arithmetic is 32-bit with natural wraparound. This is unreachable in practice because the MEM_DEPTH fault fires first.
- occupancy = count.

Test Plan:
- Reset release with fetch_enable=1, instr_ready=0, memory word i holding i+100:
  - cycles 1-4 push PCs 0..3; occupancy reads 1,2,3,4;
  - mem_read_address then holds at 4; instr_valid=1 with instr_pc=0, instr_data=100.
- Full queue (DEPTH=4) with instr_ready held at 1:
  - one word is popped and one pushed per cycle; occupancy stays 4;
  - instr_pc steps 0,1,2,…; no PC is skipped or duplicated.
- Redirect_valid pulsed with redirect_pc=0x40 while occupancy=3:
  - instr_valid=0 in the redirect cycle; occupancy=0 the next cycle;
  - in the following cycle instr_pc=0x40, instr_data=mem[0x40].
- redirect_pc=2046 with instr_ready=0:
  - PCs 2046 and 2047 are queued; fetch_fault=1 one cycle after the attempt at 2048; mem_read_address stays 2048;
  - both entries then drain with instr_ready=1; a redirect to 0 clears the fault.
- rst_n dropped asynchronously mid-cycle with occupancy=2:
  - instr_valid and occupancy go to 0 without a clock edge;
  - after release, fetching restarts at RESET_PC.
- fetch_enable=0 with occupancy=2 and instr_ready=1:
  - entries drain over 2 cycles, then instr_valid=0;
  - mem_read_address is unchanged throughout.
